hamming_serial_rx: RTL and testbench
====================================

# hamming_serial_rx

Single-clock serial receiver for the Hamming (7,4) link. It deserializes a gated bitstream into 7-bit codewords and computes the syndrome. It corrects any single-bit error and presents the 4-bit data nibble on a valid/ready output with per-word error status. It is the far end of the serial encoder path and replaces the dual-clock decode chain with one clock domain plus flow control.

## Interface
- CNT_W, 8, width of the saturating corrected-error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bit_in  in  1  serial code bit, sampled when bit_valid=1
- bit_valid  in  1  qualifies bit_in for this cycle
- sync_clr  in  1  synchronous frame restart (discard partial codeword)
- out_ready  in  1  downstream accepts data_out this cycle
- data_out  out  4  corrected nibble {c7,c6,c5,c3} (bit0=c3)
- data_valid  out  1  data_out/err_* hold a word not yet accepted
- err_corrected  out  1  nonzero syndrome on the held word
- err_index  out  3  syndrome of the held word (bit position flipped, 0 = none)
- overrun  out  1  sticky: a completed word was dropped
- corr_count  out  CNT_W  saturating count of words with nonzero syndrome

## Operation
- Codeword positions c1..c7; parity at c1, c2, c4; data at c3, c5, c6, c7. Wire order: c1 first, c7 last.
- Syndrome s = {s4,s2,s1}: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s4=c4^c5^c6^c7. Nonzero s → invert bit c[s] before extracting data. Double errors are miscorrected by design; no detection.
- Bit counter 0..6 advances only on bit_valid. Bits land in a 7-bit shift register. On the 7th valid bit the codeword is complete. The counter wraps to 0 on that same edge.
- Completion with output slot empty, or with data_valid=1 and out_ready=1 in the same cycle: load data_out, err_corrected, err_index, and set data_valid. No bubble.
- Completion with data_valid=1 and out_ready=0: the new word is dropped, overrun is set, and the held word is unchanged.
- Handshake: a word is accepted on any edge where data_valid=1 and out_ready=1. data_valid falls unless a new word loads on that edge. data_out and err_* are stable while data_valid=1 and out_ready=0.
- corr_count increments on every completed word with s≠0, dropped words included. It saturates at 2^CNT_W−1 and never wraps.
- sync_clr: forces the bit counter to 0. Any partial codeword is discarded. If bit_valid=1 in the same cycle, that bit becomes c1 of the new frame. The output slot, overrun and corr_count are unaffected.
- Reset, including mid-frame: counter 0, shift register 0, data_out 0, data_valid 0, err_corrected 0, err_index 0, overrun 0, corr_count 0.

## Timing
- Latency: 7th bit presented with bit_valid in cycle N → data_valid=1 with the decoded word from cycle N+1.
- Throughput: one word per 7 valid bits. bit_valid may be asserted every cycle. Back-pressure never stalls bit intake; words are lost via overrun instead.
- out_ready may be high while data_valid=0 with no effect.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package hamming74_pkg holds:
  - parity/data position constants;
  - codeword width 7 and data width 4;
  - a syndrome type (3 bits).
- Sub-module hamming74_correct: purely combinational; 7-bit codeword in → 4-bit data, 3-bit syndrome, err flag out. It is reusable by any future parallel decoder.
- Top holds the bit counter, shift register, output slot and counters.

## Test plan
- Stream 1,0,1,0,1,0,1 with bit_valid every cycle and out_ready=1 → data_out=4'b1011, err_corrected=0, err_index=0, data_valid for one cycle, at N+1.
- Stream 1,0,1,0,0,0,1 (c5 flipped) → data_out=4'b1011, err_corrected=1, err_index=5, corr_count=1.
- Stream 1,0,0,0,0,0,0 (c1 flipped from all-zero) → data_out=4'b0000, err_index=1. Then stream 3 gapped bits, assert sync_clr with bit_valid=1 bit=1, and send the remaining 0,1,0,1,0,1 → data_out=4'b1011. The partial frame is discarded.
- Hold out_ready=0 and send two clean codewords (data 4'b1011 then 4'b0000) → data_out remains 4'b1011 and overrun=1. Raise out_ready → one accept, data_valid falls.
- CNT_W=2: send four codewords each with one flipped bit → corr_count=1,2,3,3 (saturated).
- Assert rst_n=0 after 4 bits of a frame, then release and send one clean frame → all outputs 0 during reset, and the first decoded word after release is correct.

Source files
------------

// File: rtl/hamming74_pkg.sv
// Shared Hamming (7,4) constants and types for the serial receiver and any future parallel decoder.
package hamming74_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  // Zero-based bit indices into a codeword vector where index i holds c(i+1).
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D3_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D5_IDX = 4;
  localparam int D6_IDX = 5;
  localparam int D7_IDX = 6;

  typedef logic [2:0] syndrome_t;

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming (7,4) single-error corrector: codeword in, data nibble and syndrome out.
module hamming74_correct
  import hamming74_pkg::*;
(
  input  logic [CW_W-1:0]   codeword,
  output logic [DATA_W-1:0] data,
  output syndrome_t         syndrome,
  output logic              err
);

  logic [CW_W-1:0] fixed;

  assign syndrome[0] = codeword[P1_IDX] ^ codeword[D3_IDX] ^ codeword[D5_IDX] ^ codeword[D7_IDX];
  assign syndrome[1] = codeword[P2_IDX] ^ codeword[D3_IDX] ^ codeword[D6_IDX] ^ codeword[D7_IDX];
  assign syndrome[2] = codeword[P4_IDX] ^ codeword[D5_IDX] ^ codeword[D6_IDX] ^ codeword[D7_IDX];
  assign err         = (syndrome != 3'd0);

  // The syndrome names the 1-based position of the flipped bit.
  always_comb begin
    fixed = codeword;
    if (err) fixed[syndrome - 3'd1] = ~codeword[syndrome - 3'd1];
  end

  assign data = {fixed[D7_IDX], fixed[D6_IDX], fixed[D5_IDX], fixed[D3_IDX]};

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial Hamming (7,4) receiver: deserializes 7-bit codewords, corrects single errors, valid/ready output.
module hamming_serial_rx
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sync_clr,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             data_valid,
  output logic             err_corrected,
  output logic [2:0]       err_index,
  output logic             overrun,
  output logic [CNT_W-1:0] corr_count
);

  // Output handshake: a word transfers on every rising edge where data_valid and
  // out_ready are both 1; while data_valid=1 and out_ready=0, data_out/err_* hold.

  logic [2:0]        bit_cnt;
  logic [CW_W-1:0]   shift_q;
  logic [CW_W-1:0]   cw_next;
  logic [DATA_W-1:0] dec_data;
  syndrome_t         dec_syn;
  logic              dec_err;
  logic              word_done;
  logic              slot_free;

  // c1 arrives first and ends up in bit 0 once seven bits have shifted in.
  assign cw_next   = {bit_in, shift_q[CW_W-1:1]};
  assign word_done = bit_valid && !sync_clr && (bit_cnt == 3'd6);
  assign slot_free = !data_valid || out_ready;

  hamming74_correct u_correct (
    .codeword (cw_next),
    .data     (dec_data),
    .syndrome (dec_syn),
    .err      (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= 3'd0;
      shift_q       <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      err_corrected <= 1'b0;
      err_index     <= 3'd0;
      overrun       <= 1'b0;
      corr_count    <= '0;
    end else begin
      if (sync_clr)       bit_cnt <= bit_valid ? 3'd1 : 3'd0;
      else if (bit_valid) bit_cnt <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;

      if (bit_valid) shift_q <= cw_next;

      if (word_done && slot_free) begin
        data_out      <= dec_data;
        err_corrected <= dec_err;
        err_index     <= dec_syn;
        data_valid    <= 1'b1;
      end else if (data_valid && out_ready) begin
        data_valid <= 1'b0;
      end

      if (word_done && !slot_free) overrun <= 1'b1;

      // Dropped words still count toward the corrected-error tally.
      if (word_done && dec_err && (corr_count != {CNT_W{1'b1}}))
        corr_count <= corr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx; a second instance with CNT_W=2 checks counter saturation.
module tb_hamming_serial_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       sync_clr;
  logic       out_ready;

  logic [3:0] data_out;
  logic       data_valid;
  logic       err_corrected;
  logic [2:0] err_index;
  logic       overrun;
  logic [7:0] corr_count;

  logic [3:0] s_data_out;
  logic       s_data_valid;
  logic       s_err_corrected;
  logic [2:0] s_err_index;
  logic       s_overrun;
  logic [1:0] s_corr_count;

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hamming_serial_rx #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .sync_clr      (sync_clr),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .err_corrected (err_corrected),
    .err_index     (err_index),
    .overrun       (overrun),
    .corr_count    (corr_count)
  );

  hamming_serial_rx #(.CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .sync_clr      (sync_clr),
    .out_ready     (out_ready),
    .data_out      (s_data_out),
    .data_valid    (s_data_valid),
    .err_corrected (s_err_corrected),
    .err_index     (s_err_index),
    .overrun       (s_overrun),
    .corr_count    (s_corr_count)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b0;
      sync_clr  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  // w is written c1..c7 left to right, so w[6] goes out first.
  task automatic send_word(input logic [6:0] w);
    for (int i = 6; i >= 0; i--) send_bit(w[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    sync_clr  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_err_corr", err_corrected, 0);
    check("rst_err_index", err_index, 0);
    check("rst_overrun", overrun, 0);
    check("rst_corr_count", corr_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // clean word, data 1011
    send_word(7'b1010101);
    check("t1_valid", data_valid, 1);
    check("t1_data", data_out, 4'b1011);
    check("t1_err", err_corrected, 0);
    check("t1_idx", err_index, 0);
    idle(1);
    check("t1_valid_drop", data_valid, 0);

    // c5 flipped
    send_word(7'b1010001);
    check("t2_valid", data_valid, 1);
    check("t2_data", data_out, 4'b1011);
    check("t2_err", err_corrected, 1);
    check("t2_idx", err_index, 5);
    check("t2_count", corr_count, 1);

    // c1 flipped from all-zero
    send_word(7'b1000000);
    check("t3_data", data_out, 4'b0000);
    check("t3_idx", err_index, 1);
    check("t3_count", corr_count, 2);
    idle(1);

    // partial frame of 3 gapped bits, then restart with sync_clr carrying c1
    send_bit(1'b1); idle(1);
    send_bit(1'b1); idle(1);
    send_bit(1'b1); idle(1);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    sync_clr  = 1'b1;
    @(negedge clk);
    sync_clr  = 1'b0;
    bit_valid = 1'b0;
    check("t3s_no_early", data_valid, 0);
    for (int i = 5; i >= 0; i--) send_bit(i[0] ? 1'b0 : 1'b1);
    check("t3s_valid", data_valid, 1);
    check("t3s_data", data_out, 4'b1011);
    check("t3s_err", err_corrected, 0);
    idle(1);

    // back-pressure: second word dropped
    out_ready = 1'b0;
    send_word(7'b1010101);
    check("t4_valid", data_valid, 1);
    check("t4_data", data_out, 4'b1011);
    check("t4_no_overrun", overrun, 0);
    send_word(7'b0000000);
    check("t4_hold_valid", data_valid, 1);
    check("t4_hold_data", data_out, 4'b1011);
    check("t4_overrun", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    check("t4_accept", data_valid, 0);
    check("t4_overrun_sticky", overrun, 1);

    // reset in the middle of a frame
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    idle(1);
    check("t5_rst_valid", data_valid, 0);
    check("t5_rst_data", data_out, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_count", corr_count, 0);
    check("t5_rst_count_sat", s_corr_count, 0);
    rst_n = 1'b1;
    idle(1);
    send_word(7'b0111100);
    check("t5_valid", data_valid, 1);
    check("t5_data", data_out, 4'b0011);
    check("t5_err", err_corrected, 0);

    // four single-error words; CNT_W=2 instance saturates at 3
    send_word(7'b0111101);
    check("t6a_data", data_out, 4'b0011);
    check("t6a_idx", err_index, 7);
    check("t6a_sat", s_corr_count, 1);
    send_word(7'b1110101);
    check("t6b_data", data_out, 4'b1011);
    check("t6b_idx", err_index, 2);
    check("t6b_sat", s_corr_count, 2);
    send_word(7'b0000010);
    check("t6c_data", data_out, 4'b0000);
    check("t6c_idx", err_index, 6);
    check("t6c_sat", s_corr_count, 3);
    send_word(7'b1000101);
    check("t6d_data", data_out, 4'b1011);
    check("t6d_idx", err_index, 3);
    check("t6d_sat", s_corr_count, 3);
    check("t6d_count", corr_count, 4);
    idle(2);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
